ws2811_rx_decoder: RTL

Receives a WS2811 single-wire NRZ pixel stream, the kind strand_driver emits, and recovers 24-bit pixel words with their strand index.
Used as the loopback checker for the strand driver in simulation and on hardware, where a spare input pin is wired to a driven strand output.
Decodes each bit from its high-pulse width and frames pixels using the reset (long-low) interval.
Reports per-pixel results, end-of-frame, and protocol errors.

---
 rtl/ws2811_pkg.sv | 17 +
 rtl/ws2811_pulse_meter.sv | 56 +++++
 rtl/ws2811_rx_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ws2811_pkg.sv
// rtl/ws2811_pkg.sv - shared WS2811 timing defaults and decoder state type
package ws2811_pkg;

  localparam int DEF_BIT_THRESH   = 26;
  localparam int DEF_MIN_HIGH     = 8;
  localparam int DEF_MAX_HIGH     = 50;
  localparam int DEF_RESET_CYCLES = 2500;
  localparam int PIXEL_BITS       = 24;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } ws_state_e;

endpackage

// File: rtl/ws2811_pulse_meter.sv
// rtl/ws2811_pulse_meter.sv - din synchronizer, edge detect and level-duration counter
module ws2811_pulse_meter #(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic                 din_s,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] high_len,
  output logic [CNT_WIDTH-1:0] low_len
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    fall    = ~sync2_q & prev_q;
    cnt_d   = cnt_q;
    if (rise || fall) begin
      cnt_d = CNT_WIDTH'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // cnt_q is the length of the level that just ended when an edge is flagged,
  // so one counter serves as the high length at a fall and the low length otherwise.
  assign din_s    = sync2_q;
  assign high_len = cnt_q;
  assign low_len  = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ws2811_rx_decoder.sv
// rtl/ws2811_rx_decoder.sv - WS2811 NRZ stream decoder: pixel assembly, framing, error flags
module ws2811_rx_decoder
  import ws2811_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int BIT_THRESH     = ws2811_pkg::DEF_BIT_THRESH,
  parameter int MIN_HIGH       = ws2811_pkg::DEF_MIN_HIGH,
  parameter int MAX_HIGH       = ws2811_pkg::DEF_MAX_HIGH,
  parameter int RESET_CYCLES   = ws2811_pkg::DEF_RESET_CYCLES,
  parameter int CNT_WIDTH      = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din,
  output logic [23:0]               pixel_data,
  output logic [MEM_ADDR_WIDTH-1:0] pixel_idx,
  output logic                      pixel_valid,
  output logic                      frame_done,
  output logic [MEM_ADDR_WIDTH-1:0] frame_count,
  output logic                      err_glitch,
  output logic                      err_long,
  output logic                      err_partial,
  output logic                      err_overflow,
  input  logic                      err_clear
);

  localparam logic [CNT_WIDTH-1:0]      THRESH_C = CNT_WIDTH'(BIT_THRESH);
  localparam logic [CNT_WIDTH-1:0]      MIN_C    = CNT_WIDTH'(MIN_HIGH);
  localparam logic [CNT_WIDTH-1:0]      MAX_C    = CNT_WIDTH'(MAX_HIGH);
  localparam logic [CNT_WIDTH-1:0]      RESET_C  = CNT_WIDTH'(RESET_CYCLES);
  localparam logic [4:0]                LAST_BIT = 5'(PIXEL_BITS - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] IDX_MAX  = {MEM_ADDR_WIDTH{1'b1}};

  logic                 din_s, rise, fall;
  logic [CNT_WIDTH-1:0] high_len, low_len;

  ws2811_pulse_meter #(.CNT_WIDTH(CNT_WIDTH)) u_meter (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_s    (din_s),
    .rise     (rise),
    .fall     (fall),
    .high_len (high_len),
    .low_len  (low_len)
  );

  ws_state_e state_q, state_d;

  logic [23:0]               shift_q, shift_d, pixel_data_q, pixel_data_d;
  logic [4:0]                bit_cnt_q, bit_cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d, pixel_idx_q, pixel_idx_d;
  logic [MEM_ADDR_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                      full_q, full_d, any_bit_q, any_bit_d;
  logic                      pixel_valid_q, pixel_valid_d, frame_done_q, frame_done_d;
  logic                      err_glitch_q, err_glitch_d, err_long_q, err_long_d;
  logic                      err_partial_q, err_partial_d, err_overflow_q, err_overflow_d;

  logic low_done, glitch_ev, long_ev, bit_ev, bit_val, frame_end;
  logic set_partial, set_overflow;

  always_comb begin
    low_done  = ~din_s && (low_len >= RESET_C);
    glitch_ev = (state_q == HIGH) && fall && (high_len < MIN_C);
    long_ev   = (state_q == HIGH) && ((fall && (high_len > MAX_C)) || (din_s && (high_len >= MAX_C)));
    bit_ev    = (state_q == HIGH) && fall && !glitch_ev && !long_ev;
    bit_val   = (high_len >= THRESH_C);
    frame_end = (state_q == LOW) && !rise && low_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:    if (low_done) state_d = IDLE;
      IDLE:    if (rise) state_d = HIGH;
      HIGH:    if (long_ev) state_d = SYNC;
               else if (fall) state_d = LOW;
      LOW:     if (rise) state_d = HIGH;
               else if (low_done) state_d = IDLE;
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    idx_d         = idx_q;
    full_d        = full_q;
    any_bit_d     = any_bit_q;
    pixel_data_d  = pixel_data_q;
    pixel_idx_d   = pixel_idx_q;
    frame_count_d = frame_count_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    set_partial   = 1'b0;
    set_overflow  = 1'b0;

    if (bit_ev) begin
      shift_d   = {shift_q[22:0], bit_val};
      any_bit_d = 1'b1;
      if (bit_cnt_q == LAST_BIT) begin
        pixel_data_d  = {shift_q[22:0], bit_val};
        pixel_idx_d   = idx_q;
        pixel_valid_d = 1'b1;
        bit_cnt_d     = '0;
        // full_q marks that index IDX_MAX has already been handed out
        if (full_q)                set_overflow = 1'b1;
        else if (idx_q == IDX_MAX) full_d = 1'b1;
        else                       idx_d = idx_q + 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    if (frame_end) begin
      frame_done_d  = any_bit_q;
      frame_count_d = idx_q;
      set_partial   = (bit_cnt_q != '0);
    end

    if (frame_end || long_ev) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      idx_d     = '0;
      full_d    = 1'b0;
      any_bit_d = 1'b0;
    end

    err_glitch_d   = (err_glitch_q   & ~err_clear) | glitch_ev;
    err_long_d     = (err_long_q     & ~err_clear) | long_ev;
    err_partial_d  = (err_partial_q  & ~err_clear) | set_partial;
    err_overflow_d = (err_overflow_q & ~err_clear) | set_overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      idx_q          <= '0;
      full_q         <= 1'b0;
      any_bit_q      <= 1'b0;
      pixel_data_q   <= '0;
      pixel_idx_q    <= '0;
      frame_count_q  <= '0;
      pixel_valid_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      err_glitch_q   <= 1'b0;
      err_long_q     <= 1'b0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      idx_q          <= idx_d;
      full_q         <= full_d;
      any_bit_q      <= any_bit_d;
      pixel_data_q   <= pixel_data_d;
      pixel_idx_q    <= pixel_idx_d;
      frame_count_q  <= frame_count_d;
      pixel_valid_q  <= pixel_valid_d;
      frame_done_q   <= frame_done_d;
      err_glitch_q   <= err_glitch_d;
      err_long_q     <= err_long_d;
      err_partial_q  <= err_partial_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign pixel_data   = pixel_data_q;
  assign pixel_idx    = pixel_idx_q;
  assign pixel_valid  = pixel_valid_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign err_glitch   = err_glitch_q;
  assign err_long     = err_long_q;
  assign err_partial  = err_partial_q;
  assign err_overflow = err_overflow_q;

endmodule
